// File: rtl/el2_dec_gpr_sb_ctl.sv
// GPR file with write forwarding, long-latency scoreboard and collision flag.
// Storage flops are clock-gated per register; scan_mode forces clocks on.

module el2_dec_gpr_sb_ctl_cg (
    input  logic clk,
    input  logic en,
    input  logic scan_mode,
    output logic gclk
);
    logic en_lat;

    // Capture enable while clk is low so gclk is glitch-free
    always_latch begin
        if (!clk) en_lat <= en | scan_mode;
    end

    assign gclk = clk & en_lat;
endmodule

module el2_dec_gpr_sb_ctl #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRP    = 2,
    parameter int NWP    = 3,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                scan_mode,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rd,
    input  logic [NWP-1:0]      wen,
    input  logic [NWP*AW-1:0]   waddr,
    input  logic [NWP*XLEN-1:0] wd,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic [NREG-1:0]     busy,
    output logic [NRP-1:0]      rbusy,
    output logic [AW:0]         busy_cnt,
    output logic                coll_err,
    input  logic                coll_clr
);
    logic [XLEN-1:0] rf   [NREG];
    logic [XLEN-1:0] wdat [NREG];
    logic [NREG-1:0] we;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic            coll;

    // Per-register write enable and data; highest-index port wins
    always_comb begin
        we = '0;
        for (int r = 0; r < NREG; r++) wdat[r] = '0;
        for (int p = 0; p < NWP; p++) begin
            if (wen[p] && waddr[p*AW +: AW] != '0) begin
                we[waddr[p*AW +: AW]]   = 1'b1;
                wdat[waddr[p*AW +: AW]] = wd[p*XLEN +: XLEN];
            end
        end
    end

    // Two enabled ports hitting the same nonzero register
    always_comb begin
        coll = 1'b0;
        for (int p = 0; p < NWP; p++) begin
            for (int q = p + 1; q < NWP; q++) begin
                if (wen[p] && wen[q] &&
                    waddr[p*AW +: AW] == waddr[q*AW +: AW] &&
                    waddr[p*AW +: AW] != '0)
                    coll = 1'b1;
            end
        end
    end

    // Next busy vector: writes clear, sb_set sets and wins
    always_comb begin
        busy_nxt = busy & ~we;
        if (sb_set && sb_addr != '0) busy_nxt[sb_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
        cnt_nxt = '0;
        for (int r = 0; r < NREG; r++) cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
    end

    // Scoreboard, count and sticky collision state
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            busy     <= '0;
            busy_cnt <= '0;
            coll_err <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            coll_err <= coll | (coll_err & ~coll_clr);
        end
    end

    assign rf[0] = '0;

    genvar r;
    for (r = 1; r < NREG; r++) begin : g_reg
        logic            gclk;
        logic [XLEN-1:0] q;

        el2_dec_gpr_sb_ctl_cg u_cg (
            .clk       (clk),
            .en        (we[r]),
            .scan_mode (scan_mode),
            .gclk      (gclk)
        );

        // Storage register, clocked only when written
        always_ff @(posedge gclk or negedge rst_l) begin
            if (!rst_l) q <= '0;
            else        q <= wdat[r];
        end

        assign rf[r] = q;
    end

    // Combinational read with optional same-cycle forwarding
    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        logic            hit;
        rd    = '0;
        rbusy = '0;
        a     = '0;
        v     = '0;
        hit   = 1'b0;
        for (int i = 0; i < NRP; i++) begin
            a   = raddr[i*AW +: AW];
            v   = rf[a];
            hit = 1'b0;
            if (BYPASS != 0) begin
                for (int p = 0; p < NWP; p++) begin
                    if (wen[p] && waddr[p*AW +: AW] == a && a != '0) begin
                        v   = wd[p*XLEN +: XLEN];
                        hit = 1'b1;
                    end
                end
            end
            rd[i*XLEN +: XLEN] = v;
            rbusy[i]           = busy[a] & ~hit;
        end
    end
endmodule

// File: doc/el2_dec_gpr_sb_ctl.md
EL2_DEC_GPR_SB_CTL -- requirements
Module: el2_dec_gpr_sb_ctl

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, register count; power of 2, at least 4; AW = clog2(NREG).
REQ-003 SHALL have parameter NRP, default 2, read port count, 1..4.
REQ-004 SHALL have parameter NWP, default 3, write port count, 1..4.
REQ-005 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable (0/1).
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port rst_l, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port scan_mode, input, 1, clock-gate test override.
REQ-009 SHALL have port raddr, input, NRP*AW, read addresses; port i at bits [i*AW +: AW].
REQ-010 SHALL have port rd, output, NRP*XLEN, read data, packed like raddr.
REQ-011 SHALL have port wen, input, NWP, per-port write enables.
REQ-012 SHALL have port waddr, input, NWP*AW, write addresses.
REQ-013 SHALL have port wd, input, NWP*XLEN, write data.
REQ-014 SHALL have port sb_set, input, 1, marks register sb_addr busy (long-latency op issued).
REQ-015 SHALL have port sb_addr, input, AW, scoreboard set address.
REQ-016 SHALL have port busy, output, NREG, registered per-register busy flags.
REQ-017 SHALL have port rbusy, output, NRP, read-port operand-not-ready flags.
REQ-018 SHALL have port busy_cnt, output, AW+1, count of set busy bits.
REQ-019 SHALL have port coll_err, output, 1, sticky write-collision flag.
REQ-020 SHALL have port coll_clr, input, 1, clears coll_err.

Function
REQ-021 Register 0 SHALL read as 0, ignore writes, never be busy; busy[0] tied 0.
REQ-022 Enabled write to nonzero address SHALL update storage at the rising edge; visible in storage the next cycle.
REQ-023 Per register, write enable SHALL be the OR of matching enabled ports; storage flops SHALL be clock-gated on it, with scan_mode forcing clocks on.
REQ-024 Reads SHALL be combinational, zero latency.
REQ-025 With BYPASS=1, a same-cycle enabled write to a read's nonzero address SHALL forward wd to rd; with BYPASS=0, rd SHALL show the stored value.
REQ-026 Two or more enabled write ports to one nonzero address SHALL resolve so the highest-index port wins, for both storage and bypass.
REQ-027 Such a collision SHALL set coll_err at the next edge; it SHALL stay set until coll_clr or reset; collision concurrent with coll_clr SHALL leave coll_err set.
REQ-028 sb_set to a nonzero address SHALL set busy[sb_addr] at the next edge; sb_set to address 0 SHALL be ignored.
REQ-029 Any enabled write to address a SHALL clear busy[a] at the next edge.
REQ-030 sb_set and a write to the same address in one cycle SHALL leave busy set (set wins).
REQ-031 rbusy[i] SHALL equal busy[raddr_i]; with BYPASS=1 it SHALL be 0 when a same-cycle write targets raddr_i.
REQ-032 busy_cnt SHALL be registered and always equal popcount(busy); it cannot exceed NREG-1.
REQ-033 sb_set to an already-busy register SHALL not change busy or busy_cnt.

Reset
REQ-034 On rst_l low, all registers, busy, busy_cnt and coll_err SHALL clear to 0 immediately, regardless of clk.
REQ-035 While rst_l is low, writes and sb_set SHALL be ignored; first state update occurs at the first edge after deassertion.
REQ-036 Reset asserted mid-operation (pending busy bits, collision) SHALL discard all state without residue.

Verification
REQ-037 Write wen=001, waddr0=5, wd0=0xDEADBEEF; next cycle read raddr0=5 -> rd0=0xDEADBEEF; same-cycle read with BYPASS=1 -> 0xDEADBEEF, with BYPASS=0 -> old value 0.
REQ-038 wen=111, all waddr=7, wd=0x1,0x2,0x3 -> reg7=0x3 next cycle, coll_err=1; pulse coll_clr with no collision -> coll_err=0 next cycle.
REQ-039 Write reg 0 with 0xFFFFFFFF, sb_set sb_addr=0 -> rd for raddr=0 stays 0, busy=0, busy_cnt=0.
REQ-040 sb_set to 3, then sb_set to 9 -> busy_cnt=2, rbusy high reading 3; write reg 3 -> busy[3]=0, busy_cnt=1; same-cycle rbusy=0 when BYPASS=1.
REQ-041 sb_set and write both to reg 12 in one cycle -> busy[12]=1 next cycle, reg12 holds written data.
REQ-042 With busy[4]=1, coll_err=1, reg4=0x55: assert rst_l low between edges -> all outputs 0 immediately; after release, reads return 0.
